// File: rtl/instr_item_encoder.sv
// ---------------------------------------------------------------------------
// instr_item_encoder
//
// Turns verification instruction items (code + rs1/rs2/rd + 32-bit immediate)
// into RV32I machine words. Each emitted word carries the byte address it
// occupies in the generated instruction image. It is the inverse of the core
// decoder and is used to build memory images and golden fetch streams.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   restart       reload the address counter to BASE_ADDR and clear the
//                 counters; a word already in the output register is kept
//   in_valid/in_ready                      item handshake
//   in_instr, in_rs1, in_rs2, in_rd, in_imm item fields
//   out_valid/out_ready                    word handshake
//   out_word, out_addr, out_err            encoded word, byte address, and
//                                          the illegal-code flag
//   word_count, err_count                  saturating transfer counters
// ---------------------------------------------------------------------------
module instr_item_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_instr,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] word_count,
    output logic [7:0]  err_count
);

    // Instruction codes, in the verification enum order
    localparam logic [5:0] C_ADDI  = 6'd0,  C_SLTI  = 6'd1,  C_SLTIU = 6'd2;
    localparam logic [5:0] C_ORI   = 6'd3,  C_XORI  = 6'd4,  C_ANDI  = 6'd5;
    localparam logic [5:0] C_SLLI  = 6'd6,  C_SRLI  = 6'd7,  C_SRAI  = 6'd8;
    localparam logic [5:0] C_JALR  = 6'd9,  C_LW    = 6'd10, C_LB    = 6'd11;
    localparam logic [5:0] C_LH    = 6'd12, C_LBU   = 6'd13, C_LHU   = 6'd14;
    localparam logic [5:0] C_ADD   = 6'd15, C_SUB   = 6'd16, C_SLL   = 6'd17;
    localparam logic [5:0] C_SLT   = 6'd18, C_SLTU  = 6'd19, C_XOR   = 6'd20;
    localparam logic [5:0] C_SRL   = 6'd21, C_SRA   = 6'd22, C_OR    = 6'd23;
    localparam logic [5:0] C_AND   = 6'd24, C_LUI   = 6'd25, C_AUIPC = 6'd26;
    localparam logic [5:0] C_JAL   = 6'd27, C_SW    = 6'd28, C_SB    = 6'd29;
    localparam logic [5:0] C_SH    = 6'd30, C_BEQ   = 6'd31, C_BNE   = 6'd32;
    localparam logic [5:0] C_BLT   = 6'd33, C_BLTU  = 6'd34, C_BGE   = 6'd35;
    localparam logic [5:0] C_BGEU  = 6'd36;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_STD = 7'b0000000;

    // ------------------------------------------------------------------
    // Format builders. Each takes only the immediate bits its format
    // keeps, so truncation of out-of-field bits is explicit at the caller.
    // ------------------------------------------------------------------
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] sh_type(input logic [6:0] f7, input logic [4:0] shamt,
                                            input logic [4:0] rs1, input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {f7, shamt, rs1, f3, rd, OP_IMM};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    // imm12_1 holds byte-offset bits [12:1]; bit 0 is always dropped
    function automatic logic [31:0] b_type(input logic [12:1] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] u_type(input logic [31:12] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] j_type(input logic [20:1] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    // Returns {illegal, word}
    function automatic logic [32:0] encode_item(input logic [5:0]  code,
                                                input logic [4:0]  rs1,
                                                input logic [4:0]  rs2,
                                                input logic [4:0]  rd,
                                                input logic [31:0] imm);
        logic [31:0] w;
        logic        err;
        w   = NOP_WORD;
        err = 1'b0;
        case (code)
            C_ADDI:  w = i_type(imm[11:0], rs1, 3'b000, rd, OP_IMM);
            C_SLTI:  w = i_type(imm[11:0], rs1, 3'b010, rd, OP_IMM);
            C_SLTIU: w = i_type(imm[11:0], rs1, 3'b011, rd, OP_IMM);
            C_XORI:  w = i_type(imm[11:0], rs1, 3'b100, rd, OP_IMM);
            C_ORI:   w = i_type(imm[11:0], rs1, 3'b110, rd, OP_IMM);
            C_ANDI:  w = i_type(imm[11:0], rs1, 3'b111, rd, OP_IMM);
            C_SLLI:  w = sh_type(F7_STD, imm[4:0], rs1, 3'b001, rd);
            C_SRLI:  w = sh_type(F7_STD, imm[4:0], rs1, 3'b101, rd);
            C_SRAI:  w = sh_type(F7_ALT, imm[4:0], rs1, 3'b101, rd);
            C_JALR:  w = i_type(imm[11:0], rs1, 3'b000, rd, OP_JALR);
            C_LB:    w = i_type(imm[11:0], rs1, 3'b000, rd, OP_LOAD);
            C_LH:    w = i_type(imm[11:0], rs1, 3'b001, rd, OP_LOAD);
            C_LW:    w = i_type(imm[11:0], rs1, 3'b010, rd, OP_LOAD);
            C_LBU:   w = i_type(imm[11:0], rs1, 3'b100, rd, OP_LOAD);
            C_LHU:   w = i_type(imm[11:0], rs1, 3'b101, rd, OP_LOAD);
            C_ADD:   w = r_type(F7_STD, rs2, rs1, 3'b000, rd);
            C_SUB:   w = r_type(F7_ALT, rs2, rs1, 3'b000, rd);
            C_SLL:   w = r_type(F7_STD, rs2, rs1, 3'b001, rd);
            C_SLT:   w = r_type(F7_STD, rs2, rs1, 3'b010, rd);
            C_SLTU:  w = r_type(F7_STD, rs2, rs1, 3'b011, rd);
            C_XOR:   w = r_type(F7_STD, rs2, rs1, 3'b100, rd);
            C_SRL:   w = r_type(F7_STD, rs2, rs1, 3'b101, rd);
            C_SRA:   w = r_type(F7_ALT, rs2, rs1, 3'b101, rd);
            C_OR:    w = r_type(F7_STD, rs2, rs1, 3'b110, rd);
            C_AND:   w = r_type(F7_STD, rs2, rs1, 3'b111, rd);
            C_LUI:   w = u_type(imm[31:12], rd, OP_LUI);
            C_AUIPC: w = u_type(imm[31:12], rd, OP_AUIPC);
            C_JAL:   w = j_type(imm[20:1], rd);
            C_SB:    w = s_type(imm[11:0], rs2, rs1, 3'b000);
            C_SH:    w = s_type(imm[11:0], rs2, rs1, 3'b001);
            C_SW:    w = s_type(imm[11:0], rs2, rs1, 3'b010);
            C_BEQ:   w = b_type(imm[12:1], rs2, rs1, 3'b000);
            C_BNE:   w = b_type(imm[12:1], rs2, rs1, 3'b001);
            C_BLT:   w = b_type(imm[12:1], rs2, rs1, 3'b100);
            C_BGE:   w = b_type(imm[12:1], rs2, rs1, 3'b101);
            C_BLTU:  w = b_type(imm[12:1], rs2, rs1, 3'b110);
            C_BGEU:  w = b_type(imm[12:1], rs2, rs1, 3'b111);
            default: begin
                w   = NOP_WORD;
                err = 1'b1;
            end
        endcase
        return {err, w};
    endfunction

    // ------------------------------------------------------------------
    // Output register, address counter and transfer counters
    // ------------------------------------------------------------------
    logic        out_valid_q;
    logic [31:0] out_word_q;
    logic [31:0] out_addr_q;
    logic        out_err_q;
    logic [31:0] next_addr_q, next_addr_d;
    logic [15:0] word_count_q, word_count_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        xfer;
    logic        accept;
    logic [32:0] enc;

    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = out_valid_q && out_ready;
    assign accept   = in_valid && in_ready;
    assign enc      = encode_item(in_instr, in_rs1, in_rs2, in_rd, in_imm);

    // next_addr_d is the address a word loaded at this edge receives. When
    // the current word leaves on the same edge, the follower must take
    // (its address + 4), which the registered next_addr_q cannot yet show.
    always_comb begin
        next_addr_d  = next_addr_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        if (restart) begin
            next_addr_d  = BASE_ADDR;
            word_count_d = '0;
            err_count_d  = '0;
        end else if (xfer) begin
            next_addr_d = out_addr_q + 32'd4;
            if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
            if (out_err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_addr_q   <= '0;
            out_err_q    <= 1'b0;
            next_addr_q  <= BASE_ADDR;
            word_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_word_q  <= enc[31:0];
                out_err_q   <= enc[32];
                out_addr_q  <= next_addr_d;
            end else if (xfer) begin
                out_valid_q <= 1'b0;
            end
            next_addr_q  <= next_addr_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign out_addr   = out_addr_q;
    assign out_err    = out_err_q;
    assign word_count = word_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_instr_item_encoder.sv
module tb_instr_item_encoder;

    localparam logic [5:0] C_ADDI = 6'd0,  C_SLLI = 6'd6,  C_SRAI = 6'd8,  C_JALR = 6'd9;
    localparam logic [5:0] C_LBU  = 6'd13, C_ADD  = 6'd15, C_SUB  = 6'd16, C_ANDI = 6'd5;
    localparam logic [5:0] C_LUI  = 6'd25, C_AUIPC = 6'd26, C_JAL = 6'd27, C_SW   = 6'd28;
    localparam logic [5:0] C_SH   = 6'd30, C_BEQ  = 6'd31, C_BLT  = 6'd33, C_BGEU = 6'd36;

    typedef struct packed {
        logic [5:0]  code;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, restart, in_valid, out_ready;
    logic [5:0]  in_instr;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_word, out_addr;
    logic [15:0] word_count;
    logic [7:0]  err_count;

    logic        hi_in_ready, hi_out_valid, hi_out_err;
    logic [31:0] hi_out_word, hi_out_addr;
    logic [15:0] hi_word_count;
    logic [7:0]  hi_err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_item_encoder dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .out_err(out_err),
        .word_count(word_count), .err_count(err_count)
    );

    instr_item_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(hi_in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(hi_out_valid), .out_ready(out_ready),
        .out_word(hi_out_word), .out_addr(hi_out_addr), .out_err(hi_out_err),
        .word_count(hi_word_count), .err_count(hi_err_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_instr = v.code;
        in_rd    = v.rd;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
        in_imm   = v.imm;
    endtask

    task automatic do_reset();
        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ADDI x1, x0, k  ->  (k << 20) | 0x93 for small k
    function automatic vec_t addi(input logic [31:0] k);
        return '{code: C_ADDI, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: k,
                 word: 32'h0000_0093 | (k << 20), err: 1'b0};
    endfunction

    vec_t stream [5];
    vec_t sweep  [12];
    vec_t v_jal, v_bad;

    initial begin
        stream[0] = '{C_ADD,  5'd3, 5'd1, 5'd2, 32'd0,         32'h0020_81B3, 1'b0};
        stream[1] = '{C_SW,   5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, 1'b0};
        stream[2] = '{C_BEQ,  5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_8463, 1'b0};
        stream[3] = '{C_LUI,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        stream[4] = '{C_SRAI, 5'd4, 5'd1, 5'd0, 32'd3,         32'h4030_D213, 1'b0};

        sweep[0]  = '{C_BLT,   5'd0,  5'd3, 5'd4,  32'hFFFF_FFFC, 32'hFE41_CEE3, 1'b0};
        sweep[1]  = '{C_JAL,   5'd1,  5'd0, 5'd0,  32'h0000_0800, 32'h0010_00EF, 1'b0};
        sweep[2]  = '{C_LBU,   5'd6,  5'd2, 5'd0,  32'hFFFF_FFFF, 32'hFFF1_4303, 1'b0};
        sweep[3]  = '{C_SH,    5'd31, 5'd5, 5'd6,  32'h0000_0023, 32'h0262_91A3, 1'b0};
        sweep[4]  = '{C_SUB,   5'd7,  5'd8, 5'd9,  32'd0,         32'h4094_03B3, 1'b0};
        sweep[5]  = '{C_AUIPC, 5'd2,  5'd31, 5'd31, 32'hABCD_E123, 32'hABCD_E117, 1'b0};
        sweep[6]  = '{C_SLLI,  5'd1,  5'd1, 5'd0,  32'h0000_0025, 32'h0050_9093, 1'b0};
        sweep[7]  = '{C_BGEU,  5'd0,  5'd1, 5'd2,  32'h0000_1000, 32'h8020_F063, 1'b0};
        sweep[8]  = '{6'd63,   5'd1,  5'd1, 5'd1,  32'd5,         32'h0000_0013, 1'b1};
        sweep[9]  = '{C_JALR,  5'd1,  5'd5, 5'd31, 32'h0000_0010, 32'h0102_80E7, 1'b0};
        sweep[10] = '{C_ANDI,  5'd3,  5'd4, 5'd7,  32'h0000_00FF, 32'h0FF2_7193, 1'b0};
        sweep[11] = '{C_SRAI,  5'd4,  5'd1, 5'd0,  32'hFFFF_FFE3, 32'h4030_D213, 1'b0};

        v_jal = '{C_JAL, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_006F, 1'b0};
        v_bad = '{6'd37, 5'd1, 5'd2, 5'd3, 32'd7, 32'h0000_0013, 1'b1};

        in_instr = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;

        // Reset state
        do_reset();
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check_val("rst_out_word",  out_word, 32'd0);
        check_val("rst_out_addr",  out_addr, 32'd0);
        check_val("rst_out_err",   {31'd0, out_err}, 32'd0);
        check_val("rst_word_cnt",  {16'd0, word_count}, 32'd0);
        check_val("rst_err_cnt",   {24'd0, err_count}, 32'd0);

        // Single ADDI
        drive(addi(32'd5));
        tick();
        in_valid = 1'b0;
        check_val("addi_valid", {31'd0, out_valid}, 32'd1);
        check_val("addi_word",  out_word, 32'h0050_0093);
        check_val("addi_addr",  out_addr, 32'h0);
        tick();
        check_val("addi_drained", {31'd0, out_valid}, 32'd0);
        check_val("addi_count",   {16'd0, word_count}, 32'd1);

        // Back-to-back stream, both base addresses
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(stream[i]);
            tick();
            check_val($sformatf("stream_word%0d", i), out_word, stream[i].word);
            check_val($sformatf("stream_addr%0d", i), out_addr, 32'(4 * i));
            check_val($sformatf("stream_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check_val($sformatf("stream_rdy%0d", i), {31'd0, in_ready}, 32'd1);
            if (i < 3) begin
                check_val($sformatf("hi_addr%0d", i), hi_out_addr,
                          (i == 0) ? 32'hFFFF_FFF8 : (i == 1) ? 32'hFFFF_FFFC : 32'h0000_0000);
            end
        end

        // JAL then an illegal code
        drive(v_jal);
        tick();
        check_val("jal_word", out_word, 32'h0000_006F);
        check_val("jal_addr", out_addr, 32'h14);
        drive(v_bad);
        tick();
        check_val("bad_word", out_word, 32'h0000_0013);
        check_val("bad_err",  {31'd0, out_err}, 32'd1);
        check_val("bad_addr", out_addr, 32'h18);
        in_valid = 1'b0;
        tick();
        check_val("bad_err_cnt",  {24'd0, err_count}, 32'd1);
        check_val("bad_word_cnt", {16'd0, word_count}, 32'd7);

        // Backpressure: five cycles of out_ready=0 with an item waiting
        out_ready = 1'b0;
        drive(addi(32'd1));
        tick();
        check_val("bp_word0",  out_word, 32'h0010_0093);
        check_val("bp_addr0",  out_addr, 32'h1C);
        check_val("bp_ready0", {31'd0, in_ready}, 32'd0);
        drive(addi(32'd2));
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val($sformatf("bp_hold_word%0d", k), out_word, 32'h0010_0093);
            check_val($sformatf("bp_hold_addr%0d", k), out_addr, 32'h1C);
            check_val($sformatf("bp_hold_rdy%0d", k), {31'd0, in_ready}, 32'd0);
            check_val($sformatf("bp_hold_cnt%0d", k), {16'd0, word_count}, 32'd7);
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        check_val("bp_word1", out_word, 32'h0020_0093);
        check_val("bp_addr1", out_addr, 32'h20);
        drive(addi(32'd3));
        tick();
        check_val("bp_word2", out_word, 32'h0030_0093);
        check_val("bp_addr2", out_addr, 32'h24);
        in_valid = 1'b0;
        tick();
        check_val("bp_drained", {31'd0, out_valid}, 32'd0);
        check_val("bp_count",   {16'd0, word_count}, 32'd10);

        // Restart coinciding with a transfer
        for (int i = 0; i < 3; i++) begin
            drive(addi(32'(4 + i)));
            tick();
            check_val($sformatf("rs_addr%0d", i), out_addr, 32'(32'h28 + 4 * i));
        end
        drive(addi(32'd7));
        restart = 1'b1;
        tick();
        restart = 1'b0;
        in_valid = 1'b0;
        check_val("rs_new_addr", out_addr, 32'h0);
        check_val("rs_new_word", out_word, 32'h0070_0093);
        check_val("rs_word_cnt", {16'd0, word_count}, 32'd0);
        check_val("rs_err_cnt",  {24'd0, err_count}, 32'd0);
        tick();
        check_val("rs_after_cnt", {16'd0, word_count}, 32'd1);
        check_val("rs_after_vld", {31'd0, out_valid}, 32'd0);

        // Restart while a word is held keeps that word's address
        out_ready = 1'b0;
        drive(addi(32'd2));
        tick();
        check_val("hold_addr", out_addr, 32'h4);
        in_valid = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_val("hold_rs_addr",  out_addr, 32'h4);
        check_val("hold_rs_word",  out_word, 32'h0020_0093);
        check_val("hold_rs_valid", {31'd0, out_valid}, 32'd1);
        check_val("hold_rs_cnt",   {16'd0, word_count}, 32'd0);
        out_ready = 1'b1;
        tick();
        check_val("hold_drain_cnt", {16'd0, word_count}, 32'd1);

        // Reset mid-stream with a word stalled
        drive(addi(32'd1));
        tick();
        check_val("mid_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check_val("mid_rst_cnt",   {16'd0, word_count}, 32'd0);
        check_val("mid_rst_word",  out_word, 32'd0);

        // Encoding sweep across formats and field-truncation cases
        for (int i = 0; i < 12; i++) begin
            drive(sweep[i]);
            tick();
            check_val($sformatf("enc_word%0d", i), out_word, sweep[i].word);
            check_val($sformatf("enc_err%0d", i), {31'd0, out_err}, {31'd0, sweep[i].err});
        end
        in_valid = 1'b0;
        tick();
        check_val("enc_err_cnt", {24'd0, err_count}, 32'd1);
        check_val("enc_cnt",     {16'd0, word_count}, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
